// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared definitions for the FFT sequencer slice.
//   - log2()          : ceiling log2, used for all counter/port widths
//   - state_t         : sequencer FSM states
//   - DEF_N/DEF_BF_LAT: default FFT length and butterfly latency
package fft_seq_pkg;

    localparam int unsigned DEF_N      = 8;
    localparam int unsigned DEF_BF_LAT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    // Ceiling log2; exact for the power-of-two lengths this block accepts.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_if.sv
// fft_seq_if: load handshake plus read/write address-generator controls.
//   master : sequencer client (drives i_start, i_load_valid)
//   slave  : fft_seq (drives load ready/address, rd/wr stage/pair/enable,
//            busy and done)
interface fft_seq_if
    import fft_seq_pkg::*;
#(
    parameter int unsigned N = DEF_N
) ();
    localparam int unsigned LW = log2(N);
    localparam int unsigned SW = log2(LW);

    logic          i_start;
    logic          i_load_valid;
    logic          o_load_ready;
    logic [LW-1:0] o_load_addr;
    logic [SW-1:0] o_stage;
    logic [LW-1:0] o_pair;
    logic          o_rd_en;
    logic [SW-1:0] o_wr_stage;
    logic [LW-1:0] o_wr_pair;
    logic          o_wr_en;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_start, i_load_valid,
        input  o_load_ready, o_load_addr, o_stage, o_pair, o_rd_en,
               o_wr_stage, o_wr_pair, o_wr_en, o_busy, o_done
    );

    modport slave (
        input  i_start, i_load_valid,
        output o_load_ready, o_load_addr, o_stage, o_pair, o_rd_en,
               o_wr_stage, o_wr_pair, o_wr_en, o_busy, o_done
    );
endinterface

// File: rtl/fft_seq_delay_line.sv
// fft_delay_line: DEPTH-stage register pipeline modelling the butterfly
// latency between operand read and result write-back.
//   i_clk, i_rst_n : clock, async active-low reset (clears every stage)
//   i_data         : W-bit word entering the pipe
//   o_data         : i_data delayed by exactly DEPTH cycles
module fft_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);
    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];
endmodule

// File: rtl/fft_seq.sv
// fft_seq: in-place radix-2 FFT sequencer. Loads N samples, then walks
// log2(N) stages of N/2 butterfly pairs, inserting BF_LAT idle read cycles
// after each stage so every write of a stage lands before the next stage
// reads. Write-side controls are the read-side controls delayed BF_LAT.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : start/load handshake, rd/wr stage+pair+enable,
//                    busy, done pulse
module fft_seq
    import fft_seq_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned BF_LAT = DEF_BF_LAT
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    fft_seq_if.slave  bus
);
    localparam int unsigned LW = log2(N);
    localparam int unsigned SW = log2(LW);
    localparam int unsigned DW = (BF_LAT > 1) ? log2(BF_LAT) : 1;
    localparam int unsigned PW = 1 + SW + LW;

    localparam logic [LW-1:0] LAST_ADDR  = LW'(N - 1);
    localparam logic [LW-1:0] LAST_PAIR  = LW'(N / 2 - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LW - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(BF_LAT - 1);

    state_t        r_state,     w_state_nxt;
    logic [LW-1:0] r_load_addr, w_load_addr_nxt;
    logic [LW-1:0] r_pair,      w_pair_nxt;
    logic [SW-1:0] r_stage,     w_stage_nxt;
    logic [DW-1:0] r_drain,     w_drain_nxt;

    logic          w_load_ready;
    logic          w_rd_en;
    logic [SW-1:0] w_stage_o;
    logic [LW-1:0] w_pair_o;
    logic          w_busy;
    logic          w_done;
    logic [PW-1:0] w_wr_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_load_addr <= '0;
            r_pair      <= '0;
            r_stage     <= '0;
            r_drain     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_addr <= w_load_addr_nxt;
            r_pair      <= w_pair_nxt;
            r_stage     <= w_stage_nxt;
            r_drain     <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_addr_nxt = r_load_addr;
        w_pair_nxt      = r_pair;
        w_stage_nxt     = r_stage;
        w_drain_nxt     = r_drain;
        w_load_ready    = 1'b0;
        w_rd_en         = 1'b0;
        w_stage_o       = '0;
        w_pair_o        = '0;
        w_busy          = 1'b1;
        w_done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.i_start) begin
                    w_state_nxt     = S_LOAD;
                    w_load_addr_nxt = '0;
                end
            end
            S_LOAD: begin
                w_load_ready = 1'b1;
                if (bus.i_load_valid) begin
                    // Wraps to 0 after N-1, leaving the address clean for IDLE.
                    w_load_addr_nxt = r_load_addr + LW'(1);
                    if (r_load_addr == LAST_ADDR) begin
                        w_state_nxt = S_COMPUTE;
                        w_stage_nxt = '0;
                        w_pair_nxt  = '0;
                    end
                end
            end
            S_COMPUTE: begin
                w_rd_en   = 1'b1;
                w_stage_o = r_stage;
                w_pair_o  = r_pair;
                if (r_pair == LAST_PAIR) begin
                    w_state_nxt = S_DRAIN;
                    w_pair_nxt  = '0;
                    w_drain_nxt = '0;
                end else begin
                    w_pair_nxt = r_pair + LW'(1);
                end
            end
            S_DRAIN: begin
                if (r_drain == LAST_DRAIN) begin
                    w_drain_nxt = '0;
                    if (r_stage == LAST_STAGE) begin
                        w_state_nxt = S_DONE;
                        w_stage_nxt = '0;
                    end else begin
                        w_state_nxt = S_COMPUTE;
                        w_stage_nxt = r_stage + SW'(1);
                    end
                end else begin
                    w_drain_nxt = r_drain + DW'(1);
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    fft_delay_line #(
        .DEPTH (BF_LAT),
        .W     (PW)
    ) u_wr_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  ({w_rd_en, w_stage_o, w_pair_o}),
        .o_data  (w_wr_word)
    );

    assign bus.o_load_ready = w_load_ready;
    assign bus.o_load_addr  = r_load_addr;
    assign bus.o_stage      = w_stage_o;
    assign bus.o_pair       = w_pair_o;
    assign bus.o_rd_en      = w_rd_en;
    assign bus.o_wr_en      = w_wr_word[PW-1];
    assign bus.o_wr_stage   = w_wr_word[PW-2 -: SW];
    assign bus.o_wr_pair    = w_wr_word[LW-1:0];
    assign bus.o_busy       = w_busy;
    assign bus.o_done       = w_done;
endmodule

// File: doc/fft_seq.md
FFT_SEQ -- requirements
Module: fft_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning FFT length; power of two, at least 4.
REQ-002 SHALL have parameter BF_LAT, default 2, meaning butterfly pipeline latency in cycles from read to write-back; at least 1.
REQ-003 SHALL have port i_clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  meaning a request to begin one FFT; sampled only in IDLE.
REQ-006 SHALL have port i_load_valid  input  1  meaning an input sample is present this cycle.
REQ-007 SHALL have port o_load_ready  output  1  meaning the block accepts a sample this cycle.
REQ-008 SHALL have port o_load_addr  output  log2(N)  meaning the sample index, 0..N-1, of the current load.
REQ-009 SHALL have port o_stage  output  log2(log2(N))  meaning the stage for the read-side address generator.
REQ-010 SHALL have port o_pair  output  log2(N)  meaning the butterfly pair for the read-side address generator.
REQ-011 SHALL have port o_rd_en  output  1  meaning operands at (o_stage, o_pair) are read this cycle.
REQ-012 SHALL have port o_wr_stage  output  log2(log2(N))  meaning the stage for the write-side address generator.
REQ-013 SHALL have port o_wr_pair  output  log2(N)  meaning the pair for the write-side address generator.
REQ-014 SHALL have port o_wr_en  output  1  meaning the butterfly result for (o_wr_stage, o_wr_pair) is written this cycle.
REQ-015 SHALL have port o_busy  output  1  meaning the FSM is not in IDLE.
REQ-016 SHALL have port o_done  output  1  meaning a one-cycle pulse on FFT completion.

Function
REQ-017 SHALL implement states IDLE, LOAD, COMPUTE, DRAIN and DONE.
REQ-018 IDLE->LOAD on i_start=1; i_start SHALL be ignored in every other state.
REQ-019 In LOAD: o_load_ready=1; on each cycle with valid&ready, o_load_addr SHALL increment by 1, starting at 0; after the transfer at address N-1, go to COMPUTE with stage=0, pair=0.
REQ-020 In LOAD with i_load_valid=0, the FSM SHALL hold and o_load_addr SHALL hold.
REQ-021 In COMPUTE: o_rd_en=1 every cycle; pair SHALL step 0..N/2-1, one per cycle; after pair N/2-1, go to DRAIN and clear pair to 0.
REQ-022 In DRAIN: o_rd_en=0 for exactly BF_LAT cycles, counted by a drain counter. Then, if stage=log2(N)-1, go to DONE; otherwise increment stage and go to COMPUTE.
REQ-023 o_wr_en, o_wr_stage and o_wr_pair SHALL equal o_rd_en, o_stage and o_pair delayed by exactly BF_LAT cycles.
REQ-024 As a consequence of REQ-022 and REQ-023, no read of stage s+1 SHALL occur before the last write of stage s.
REQ-025 DONE SHALL last one cycle with o_done=1, then go to IDLE; i_start in DONE is ignored.
REQ-026 o_busy SHALL be 1 in LOAD, COMPUTE, DRAIN and DONE.
REQ-027 o_stage and o_pair SHALL be 0 outside COMPUTE.
REQ-028 Compute latency from the first o_rd_en to o_done SHALL be log2(N)*(N/2+BF_LAT) cycles; this is 18 cycles for N=8, BF_LAT=2.
REQ-029 All counters SHALL be exact width and never wrap mid-stage; pair terminates at N/2-1.

Reset
REQ-030 On i_rst_n=0, immediately and asynchronously: state=IDLE, all counters=0, delay-line valids=0, and all outputs=0.
REQ-031 Reset mid-COMPUTE or mid-DRAIN SHALL suppress every pending o_wr_en; no write pulse SHALL appear after reset release until a new run.

Structure
REQ-032 A shared fft_pkg include SHALL hold the log2 function, the state encodings and the default N and BF_LAT.
REQ-033 The read-to-write delay SHALL be a sub-module fft_delay_line, parameterised by depth BF_LAT and data width, carrying {rd_en, stage, pair}, with async active-low reset.

Verification
REQ-034 Reset, then i_start pulse, then 8 back-to-back valid samples -> o_load_addr 0..7, then COMPUTE entered the cycle after addr 7.
REQ-035 Full run with N=8, BF_LAT=2 -> pairs 0,1,2,3 for each stage 0,1,2, then 2 idle read cycles per stage, then o_done 18 cycles after the first read.
REQ-036 Check every o_wr_en -> it is exactly 2 cycles after its o_rd_en with matching stage/pair; 12 writes total.
REQ-037 i_load_valid toggled 1,0,1,0 during LOAD -> address advances only on valid cycles; i_start during COMPUTE -> no effect.
REQ-038 Assert i_rst_n=0 at the 3rd cycle of stage 1 -> all outputs 0 at once, no o_wr_en afterwards, then a fresh run completes normally.
REQ-039 N=16, BF_LAT=3 -> 4 stages of 8 pairs, and o_done 4*(8+3)=44 cycles after the first read.
